bram_port_arbiter: RTL
======================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1: read latency in clocks of the attached 1 KB BlockRAM; 1 when its output register is bypassed (C5=0), 2 when enabled (C5=1).
REQ-002 Parameter WE_BIT, default 20: wr_data bit used as the dynamic write enable.
REQ-003 Parameter WA_MSB, default 16: wr_data bit carrying the write half-select.
REQ-004 Parameter RA_MSB, default 24: wr_data bit carrying the read half-select.
REQ-005 Port clk, input, 1: single clock for the block and the RAM.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Ports reqN_valid, input, 1 (N=0,1): request from requester N.
REQ-008 Ports reqN_ready, output, 1: request accepted this cycle.
REQ-009 Ports reqN_we, input, 1: 1=write, 0=read.
REQ-010 Ports reqN_addr, input, 9: halfword address.
REQ-011 Ports reqN_wdata, input, 16: write data.
REQ-012 Ports rspN_valid, output, 1: one-cycle read-response strobe for requester N.
REQ-013 Port rsp_rdata, output, 16: read data, valid while either rspN_valid is high.
REQ-014 Port clear_start, input, 1: request a zero-fill of the whole RAM.
REQ-015 Port clear_busy, output, 1: high while a clear is in progress.
REQ-016 Port clear_done, output, 1: one-cycle pulse after the last clear write.
REQ-017 Ports bram_wr_addr / bram_rd_addr, output, 8 each: RAM word addresses.
REQ-018 Port bram_wr_data, output, 32: RAM wr_data bus.
REQ-019 Port bram_rd_data, input, 32: RAM rd_data bus.

Function
REQ-020 The RAM is configured for 16-bit write and 16-bit read ports (C0..C3 = 16-bit mode), with C4=0 so that writes are dynamic.
REQ-021 Address mapping: addr[8:1] is the RAM word address; addr[0] is the half-select, driven on bram_wr_data[WA_MSB] for writes and on bram_wr_data[RA_MSB] for reads.
REQ-022 bram_wr_data is built as follows:
- [15:0] = write data.
- [WE_BIT] = 1 only in the cycle a write is driven.
- all unused bits = 0.
REQ-023 All bram_* outputs are registered; a request accepted at edge E is driven to the RAM during the cycle following E.
REQ-024 At most one operation (read, write, or clear write) is issued per cycle.
REQ-025 Arbitration in state IDLE:
- Only one reqN_valid high: that requester is granted.
- Both high: the round-robin pointer wins, and the pointer then moves to the other requester.
- reqN_ready = grant, combinational from reqN_valid and state.
REQ-026 A read accepted at edge E pulses rspN_valid for exactly the cycle following edge E+RD_LAT, with rsp_rdata = bram_rd_data[15:0].
REQ-027 An RD_LAT-deep tag pipeline routes each read response to its requester; back-to-back reads return in order, one per cycle; there is no response backpressure.
REQ-028 Writes produce no response.
REQ-029 States are IDLE and CLEAR.
REQ-030 A clear_start seen high in IDLE moves the block to CLEAR at the next edge and takes priority over pending requests.
REQ-031 In CLEAR:
- both reqN_ready = 0; clear_busy = 1.
- a 9-bit counter runs from 0 to 511, issuing one zero-write per cycle.
- after address 511 is written, clear_done pulses for one cycle and the block returns to IDLE.
REQ-032 clear_start is ignored while in CLEAR.
REQ-033 Reads accepted before a clear started still deliver their responses during CLEAR.
REQ-034 A read and a write to the same address accepted in consecutive cycles are issued in acceptance order; read data is that of the RAM at its issue edge.

Reset
REQ-035 rst_n low asynchronously forces:
- state to IDLE, round-robin pointer to requester 0, clear counter to 0.
- the tag pipeline to empty.
- all outputs to 0, including bram_wr_data[WE_BIT] (no spurious write).
REQ-036 Reset asserted mid-clear or mid-read aborts the operation; no response or clear_done is produced for it after release.
REQ-037 The first request can be accepted in the first cycle after rst_n deasserts.

Verification
REQ-038 Write, then read: req0 writes addr 0x003 data 0xBEEF; req0 reads 0x003 -> rsp0_valid exactly RD_LAT+1 cycles after the accepting edge, rsp_rdata=0xBEEF; halfword 0x002 is unchanged.
REQ-039 Contention: req0 and req1 both reading continuously for 4 cycles -> grants alternate 0,1,0,1 and each rspN_valid matches its own request.
REQ-040 Clear: fill addr 0x1FF=0x1234, pulse clear_start -> clear_busy high for 512 cycles, clear_done pulses once, and a subsequent read of 0x1FF returns 0x0000.
REQ-041 Clear with a read in flight: clear_start in the cycle after a read is accepted -> the read response is still delivered, and reqN_ready stays 0 until clear_done.
REQ-042 Reset during clear: rst_n low at clear count 100 -> outputs are 0 immediately, and no clear_done or write strobe follows after release.
REQ-043 RD_LAT=2 build: repeat REQ-038 -> response arrives one cycle later than in the RD_LAT=1 build.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a 16-bit-mode 1 KB BlockRAM with dynamic
// write enable, read-tag return pipeline and whole-RAM zero-fill.
module bram_port_arbiter #(
   parameter int RD_LAT = 1,
   parameter int WE_BIT = 20,
   parameter int WA_MSB = 16,
   parameter int RA_MSB = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_we,
   input  logic [8:0]  req0_addr,
   input  logic [15:0] req0_wdata,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_we,
   input  logic [8:0]  req1_addr,
   input  logic [15:0] req1_wdata,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [15:0] rsp_rdata,
   input  logic        clear_start,
   output logic        clear_busy,
   output logic        clear_done,
   output logic [7:0]  bram_wr_addr,
   output logic [7:0]  bram_rd_addr,
   output logic [31:0] bram_wr_data,
   input  logic [31:0] bram_rd_data
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t        state;
   logic          rr;
   logic [8:0]    clr_cnt;
   logic [RD_LAT:0] tag0;
   logic [RD_LAT:0] tag1;

   logic          idle_ok;
   logic          gnt0;
   logic          gnt1;
   logic          sel_we;
   logic [8:0]    sel_addr;
   logic [15:0]   sel_wdata;
   logic          unused_rd_hi;

   always_comb begin
      idle_ok   = (state == IDLE) && !clear_start;
      gnt0      = idle_ok && req0_valid && (!req1_valid || !rr);
      gnt1      = idle_ok && req1_valid && (!req0_valid || rr);
      sel_we    = gnt1 ? req1_we    : req0_we;
      sel_addr  = gnt1 ? req1_addr  : req0_addr;
      sel_wdata = gnt1 ? req1_wdata : req0_wdata;
   end

   assign req0_ready   = gnt0;
   assign req1_ready   = gnt1;
   assign clear_busy   = (state == CLEAR);
   assign rsp0_valid   = tag0[RD_LAT];
   assign rsp1_valid   = tag1[RD_LAT];
   assign rsp_rdata    = (rsp0_valid || rsp1_valid) ?
                         bram_rd_data[15:0] : 16'h0000;
   assign unused_rd_hi = ^bram_rd_data[31:16];

   // Stage 0 of each tag line marks the issue cycle; stage RD_LAT is the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr           <= 1'b0;
         clr_cnt      <= '0;
         tag0         <= '0;
         tag1         <= '0;
         bram_wr_addr <= '0;
         bram_rd_addr <= '0;
         bram_wr_data <= '0;
         clear_done   <= 1'b0;
      end else begin
         bram_wr_data <= '0;
         clear_done   <= 1'b0;
         tag0 <= {tag0[RD_LAT-1:0], gnt0 && !req0_we};
         tag1 <= {tag1[RD_LAT-1:0], gnt1 && !req1_we};
         unique case (state)
            IDLE: begin
               if (clear_start) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
               end else if (gnt0 || gnt1) begin
                  if (req0_valid && req1_valid)
                     rr <= ~rr;
                  if (sel_we) begin
                     bram_wr_addr         <= sel_addr[8:1];
                     bram_wr_data[15:0]   <= sel_wdata;
                     bram_wr_data[WE_BIT] <= 1'b1;
                     bram_wr_data[WA_MSB] <= sel_addr[0];
                  end else begin
                     bram_rd_addr         <= sel_addr[8:1];
                     bram_wr_data[RA_MSB] <= sel_addr[0];
                  end
               end
            end
            CLEAR: begin
               bram_wr_addr         <= clr_cnt[8:1];
               bram_wr_data[WE_BIT] <= 1'b1;
               bram_wr_data[WA_MSB] <= clr_cnt[0];
               clr_cnt              <= clr_cnt + 9'd1;
               if (clr_cnt == 9'd511) begin
                  state      <= IDLE;
                  clear_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
